// File: rtl/rv32i_lsu_if.sv
`default_nettype none
// =============================================================================
// rv32i_lsu_if : core-side request/response and data-memory bus of the LSU
// Rev 1.0
// =============================================================================
interface rv32i_lsu_if;
  logic        core_req_valid;
  logic        core_req_we;
  logic [2:0]  core_req_funct3;
  logic [31:0] core_req_addr;
  logic [31:0] core_req_wdata;
  logic        core_stall;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_rdata;
  logic        core_err;
  logic [1:0]  core_err_cause;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  // LSU side
  modport slave (
    input  core_req_valid, core_req_we, core_req_funct3, core_req_addr, core_req_wdata,
    output core_stall, core_rsp_valid, core_rsp_rdata, core_err, core_err_cause,
    output mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  // Core datapath and memory side
  modport master (
    output core_req_valid, core_req_we, core_req_funct3, core_req_addr, core_req_wdata,
    input  core_stall, core_rsp_valid, core_rsp_rdata, core_err, core_err_cause,
    input  mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/rv32i_lsu.sv
`default_nettype none
// =============================================================================
// rv32i_lsu : RV32I load/store unit with lane steering, fault checks, bus timeout
// Rev 1.0
// =============================================================================
module rv32i_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  rv32i_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int                c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  state_t             r_state, w_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_funct3;
  logic [1:0]         r_off;
  logic               r_we;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [1:0]         r_cause;
  logic               r_mem_req_valid;
  logic [31:0]        r_mem_addr;
  logic               r_mem_we;
  logic [3:0]         r_mem_be;
  logic [31:0]        r_mem_wdata;

  logic               w_illegal, w_misaligned, w_take_rsp, w_timeout;
  logic [1:0]         w_fault_cause;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata, w_lane, w_load_data;

  // Illegal encoding outranks misalignment
  assign w_illegal = bus.core_req_we ? (bus.core_req_funct3 >= 3'b011)
                                     : (bus.core_req_funct3 == 3'b011 || bus.core_req_funct3[2:1] == 2'b11);
  assign w_misaligned = (bus.core_req_funct3[1:0] == 2'b01 && bus.core_req_addr[0]) ||
                        (bus.core_req_funct3[1:0] == 2'b10 && bus.core_req_addr[1:0] != 2'b00);
  assign w_fault_cause = w_illegal ? 2'b10 : (w_misaligned ? 2'b01 : 2'b00);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.core_req_wdata;
    if (bus.core_req_we) begin
      case (bus.core_req_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << bus.core_req_addr[1:0];
          w_wdata = {4{bus.core_req_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = bus.core_req_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{bus.core_req_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign w_lane = bus.mem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load_data = bus.mem_rdata;
      3'b100:  w_load_data = {24'd0, w_lane[7:0]};
      3'b101:  w_load_data = {16'd0, w_lane[15:0]};
      default: w_load_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // A response outranks an expiring counter in the same cycle
  always_comb begin
    w_next     = r_state;
    w_take_rsp = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.core_req_valid) w_next = (w_fault_cause != 2'b00) ? S_DONE : S_REQ;
      S_REQ: begin
        if (bus.mem_req_ready && bus.mem_rsp_valid) begin
          w_take_rsp = 1'b1;
          w_next     = S_DONE;
        end else if (r_cnt == c_cnt_last) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end else if (bus.mem_req_ready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          w_take_rsp = 1'b1;
          w_next     = S_DONE;
        end else if (r_cnt == c_cnt_last) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt           <= '0;
      r_funct3        <= 3'd0;
      r_off           <= 2'd0;
      r_we            <= 1'b0;
      r_rdata         <= 32'd0;
      r_err           <= 1'b0;
      r_cause         <= 2'b00;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= 32'd0;
      r_mem_we        <= 1'b0;
      r_mem_be        <= 4'd0;
      r_mem_wdata     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.core_req_valid) begin
            r_rdata <= 32'd0;
            r_err   <= (w_fault_cause != 2'b00);
            r_cause <= w_fault_cause;
            if (w_fault_cause == 2'b00) begin
              r_funct3        <= bus.core_req_funct3;
              r_off           <= bus.core_req_addr[1:0];
              r_we            <= bus.core_req_we;
              r_mem_req_valid <= 1'b1;
              r_mem_addr      <= {bus.core_req_addr[31:2], 2'b00};
              r_mem_we        <= bus.core_req_we;
              r_mem_be        <= w_be;
              r_mem_wdata     <= w_wdata;
            end
          end
        end
        S_REQ, S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_next != S_REQ) r_mem_req_valid <= 1'b0;
          if (w_take_rsp && !r_we) r_rdata <= w_load_data;
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_cause <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.core_stall     = (r_state == S_IDLE && bus.core_req_valid) ||
                              r_state == S_REQ || r_state == S_WAIT;
  assign bus.core_rsp_valid = (r_state == S_DONE);
  assign bus.core_rsp_rdata = (r_state == S_DONE) ? r_rdata : 32'd0;
  assign bus.core_err       = (r_state == S_DONE) && r_err;
  assign bus.core_err_cause = (r_state == S_DONE) ? r_cause : 2'b00;
  assign bus.mem_req_valid  = r_mem_req_valid;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_we         = r_mem_we;
  assign bus.mem_be         = r_mem_be;
  assign bus.mem_wdata      = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_lsu.sv
`default_nettype none
// =============================================================================
// tb_rv32i_lsu : table-driven and randomized checks of rv32i_lsu against a reference model
// Rev 1.0
// =============================================================================
module tb_rv32i_lsu;
  localparam int TO = 8;

  typedef struct {
    logic [1:0]  cause;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    int          stalls;
    bit          req;
  } exp_t;

  typedef struct {
    string       name;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int          rdy;
    int          rsp;
    exp_t        exp;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  rv32i_lsu_if bus ();
  rv32i_lsu #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return {21'd0, bus.core_stall, bus.core_rsp_valid, bus.core_rsp_rdata, bus.core_err,
            bus.core_err_cause, bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_be,
            bus.mem_wdata};
  endfunction

  // Reference: access size from funct3, lanes by byte offset arithmetic, timing from bus delays
  function automatic exp_t model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] word,
                                 input int rdy, input int rsp);
    exp_t e;
    int off, size, busy;
    bit legal;
    longint unsigned mask, v, rep;
    e.cause = 2'd0; e.be = 4'hF; e.mwdata = 32'd0; e.rdata = 32'd0; e.stalls = 1; e.req = 1'b0;
    off   = int'(addr % 32'd4);
    size  = 1 << int'(f3 % 3'd4);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) e.cause = 2'd2;
    else if (off % size != 0) e.cause = 2'd1;
    if (e.cause != 2'd0) return e;
    e.req = 1'b1;
    busy  = rdy + 1 + rsp;
    if (busy > TO) begin
      e.cause  = 2'd3;
      e.stalls = 1 + TO;
    end else begin
      e.stalls = 1 + busy;
    end
    mask = (64'd1 << (8 * size)) - 64'd1;
    if (we) begin
      e.be     = 4'(((1 << size) - 1) << off);
      rep      = (size == 1) ? 64'h01010101 : ((size == 2) ? 64'h00010001 : 64'd1);
      v        = wdata;
      v        = (v & mask) * rep;
      e.mwdata = v[31:0];
    end else if (e.cause == 2'd0) begin
      v = word;
      v = (v >> (8 * off)) & mask;
      if (f3 < 3'd4 && size < 4 && v >= (mask + 64'd1) / 2) v = v - (mask + 64'd1);
      e.rdata = v[31:0];
    end
    return e;
  endfunction

  function automatic vec_t mkvec(input string name, input bit we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] word, input int rdy, input int rsp,
                                 input logic [1:0] cause, input logic [3:0] be,
                                 input logic [31:0] mwdata, input logic [31:0] rdata,
                                 input int stalls, input bit req);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.word = word;
    v.rdy = rdy; v.rsp = rsp;
    v.exp.cause = cause; v.exp.be = be; v.exp.mwdata = mwdata; v.exp.rdata = rdata;
    v.exp.stalls = stalls; v.exp.req = req;
    return v;
  endfunction

  // Drives one access from an IDLE cycle and plays the memory; returns in the DONE cycle
  task automatic run_access(input vec_t v);
    int  stalls = 0, req_cnt = 0, wait_cnt = 0;
    bit  saw_req = 1'b0, done = 1'b0;
    logic [31:0] exp_addr;
    exp_addr = v.addr;
    exp_addr[1:0] = 2'b00;
    @(negedge clk);
    bus.core_req_valid  = 1'b1;
    bus.core_req_we     = v.we;
    bus.core_req_funct3 = v.f3;
    bus.core_req_addr   = v.addr;
    bus.core_req_wdata  = v.wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = $urandom;
      #1;
      if (bus.core_rsp_valid) begin
        done = 1'b1;
        check({v.name, ".err"},    128'(bus.core_err), 128'(v.exp.cause != 2'd0));
        check({v.name, ".cause"},  128'(bus.core_err_cause), 128'(v.exp.cause));
        check({v.name, ".rdata"},  128'(bus.core_rsp_rdata), 128'(v.exp.rdata));
        check({v.name, ".stalls"}, 128'(stalls), 128'(v.exp.stalls));
        check({v.name, ".stall_done"}, 128'(bus.core_stall), 128'd0);
        check({v.name, ".bus_used"},   128'(saw_req), 128'(v.exp.req));
        bus.core_req_valid = 1'b0;
      end else begin
        if (bus.core_stall) stalls++;
        if (bus.mem_req_valid) begin
          if (!saw_req) begin
            saw_req = 1'b1;
            check({v.name, ".mem_addr"}, 128'(bus.mem_addr), 128'(exp_addr));
            check({v.name, ".mem_we"},   128'(bus.mem_we), 128'(v.we));
            check({v.name, ".mem_be"},   128'(bus.mem_be), 128'(v.exp.be));
            if (v.we) check({v.name, ".mem_wdata"}, 128'(bus.mem_wdata), 128'(v.exp.mwdata));
          end
          if (req_cnt == v.rdy) begin
            bus.mem_req_ready = 1'b1;
            if (v.rsp == 0) begin
              bus.mem_rsp_valid = 1'b1;
              bus.mem_rdata     = v.word;
            end
          end
          req_cnt++;
        end else if (saw_req) begin
          wait_cnt++;
          if (wait_cnt == v.rsp) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = v.word;
          end
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.complete: no core_rsp_valid within 40 cycles", v.name);
      bus.core_req_valid = 1'b0;
    end
  endtask

  vec_t tbl[20];
  vec_t rv;

  initial begin
    reset_n = 1'b0;
    bus.core_req_valid = 1'b0; bus.core_req_we = 1'b0; bus.core_req_funct3 = 3'd0;
    bus.core_req_addr = 32'd0; bus.core_req_wdata = 32'd0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'd0;

    tbl[0]  = mkvec("lw_wait3",   0, 3'b010, 32'h80001004, 32'h0, 32'hDEADBEEF, 0, 3, 2'd0, 4'hF, 32'h0, 32'hDEADBEEF, 5, 1);
    tbl[1]  = mkvec("lb_neg",     0, 3'b000, 32'h00000103, 32'h0, 32'h80FF0000, 0, 0, 2'd0, 4'hF, 32'h0, 32'hFFFFFF80, 2, 1);
    tbl[2]  = mkvec("lbu",        0, 3'b100, 32'h00000103, 32'h0, 32'h80FF0000, 0, 0, 2'd0, 4'hF, 32'h0, 32'h00000080, 2, 1);
    tbl[3]  = mkvec("lhu_hi",     0, 3'b101, 32'h00000102, 32'h0, 32'h80FF0000, 0, 0, 2'd0, 4'hF, 32'h0, 32'h000080FF, 2, 1);
    tbl[4]  = mkvec("lh_hi",      0, 3'b001, 32'h00000102, 32'h0, 32'h80FF0000, 1, 1, 2'd0, 4'hF, 32'h0, 32'hFFFF80FF, 4, 1);
    tbl[5]  = mkvec("sb_lane1",   1, 3'b000, 32'h00000201, 32'h123456AB, 32'h0, 1, 2, 2'd0, 4'b0010, 32'hABABABAB, 32'h0, 5, 1);
    tbl[6]  = mkvec("sh_hi",      1, 3'b001, 32'h00000202, 32'h123456AB, 32'h0, 0, 1, 2'd0, 4'b1100, 32'h56AB56AB, 32'h0, 3, 1);
    tbl[7]  = mkvec("sw",         1, 3'b010, 32'h00000300, 32'hCAFEF00D, 32'h0, 0, 0, 2'd0, 4'b1111, 32'hCAFEF00D, 32'h0, 2, 1);
    tbl[8]  = mkvec("lw_misal",   0, 3'b010, 32'h00000002, 32'h0, 32'h0, 0, 0, 2'd1, 4'hF, 32'h0, 32'h0, 1, 0);
    tbl[9]  = mkvec("ld_f3_011",  0, 3'b011, 32'h00000000, 32'h0, 32'h0, 0, 0, 2'd2, 4'hF, 32'h0, 32'h0, 1, 0);
    tbl[10] = mkvec("ld_f3_110",  0, 3'b110, 32'h00000001, 32'h0, 32'h0, 0, 0, 2'd2, 4'hF, 32'h0, 32'h0, 1, 0);
    tbl[11] = mkvec("st_f3_011",  1, 3'b011, 32'h00000000, 32'h0, 32'h0, 0, 0, 2'd2, 4'hF, 32'h0, 32'h0, 1, 0);
    tbl[12] = mkvec("sh_misal",   1, 3'b001, 32'h00000001, 32'h0, 32'h0, 0, 0, 2'd1, 4'hF, 32'h0, 32'h0, 1, 0);
    tbl[13] = mkvec("lhu_misal",  0, 3'b101, 32'h00000003, 32'h0, 32'h0, 0, 0, 2'd1, 4'hF, 32'h0, 32'h0, 1, 0);
    tbl[14] = mkvec("lw_noready", 0, 3'b010, 32'h00000400, 32'h0, 32'h0, 100, 0, 2'd3, 4'hF, 32'h0, 32'h0, 9, 1);
    tbl[15] = mkvec("lw_rdy_last",0, 3'b010, 32'h00000404, 32'h0, 32'h11223344, 7, 0, 2'd0, 4'hF, 32'h0, 32'h11223344, 9, 1);
    tbl[16] = mkvec("lw_rsp_late",0, 3'b010, 32'h00000408, 32'h0, 32'h55667788, 0, 8, 2'd3, 4'hF, 32'h0, 32'h0, 9, 1);
    tbl[17] = mkvec("lw_rsp_last",0, 3'b010, 32'h0000040C, 32'h0, 32'h0BADF00D, 0, 7, 2'd0, 4'hF, 32'h0, 32'h0BADF00D, 9, 1);
    tbl[18] = mkvec("lb_pos",     0, 3'b000, 32'h00000600, 32'h0, 32'h0000007F, 0, 0, 2'd0, 4'hF, 32'h0, 32'h0000007F, 2, 1);
    tbl[19] = mkvec("lhu_lo",     0, 3'b101, 32'h00000700, 32'h0, 32'hFFFF8001, 0, 0, 2'd0, 4'hF, 32'h0, 32'h00008001, 2, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outputs(), 128'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) run_access(tbl[i]);

    // Timed-out access followed by a stray response in DONE and IDLE
    run_access(tbl[14]);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'hFFFFFFFF;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    #1;
    check("late_rsp.idle_rsp_valid", 128'(bus.core_rsp_valid), 128'd0);
    check("late_rsp.idle_stall", 128'(bus.core_stall), 128'd0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    #1;
    check("late_rsp.after", 128'({bus.core_rsp_valid, bus.core_stall, bus.mem_req_valid}), 128'd0);

    // Reset while waiting for read data
    @(negedge clk);
    bus.core_req_valid = 1'b1; bus.core_req_we = 1'b0;
    bus.core_req_funct3 = 3'b010; bus.core_req_addr = 32'h00000500;
    @(negedge clk);
    #1;
    check("rst_wait.req_valid", 128'(bus.mem_req_valid), 128'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    check("rst_wait.in_wait", 128'({bus.mem_req_valid, bus.core_stall}), 128'b01);
    reset_n = 1'b0;
    bus.core_req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_wait.outputs", all_outputs(), 128'd0);
    reset_n = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    #1;
    check("rst_wait.no_rsp", 128'({bus.core_rsp_valid, bus.core_stall}), 128'd0);
    run_access(tbl[0]);

    // Randomized accesses against the reference model
    for (int i = 0; i < 60; i++) begin
      rv.name  = $sformatf("rand%0d", i);
      rv.we    = 1'($urandom_range(0, 1));
      rv.f3    = 3'($urandom_range(0, 7));
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.word  = $urandom;
      rv.rdy   = $urandom_range(0, 5);
      rv.rsp   = $urandom_range(0, 5);
      rv.exp   = model(rv.we, rv.f3, rv.addr, rv.wdata, rv.word, rv.rdy, rv.rsp);
      run_access(rv);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
